// File: rtl/pipe_pkg.sv
// Shared types for the pipeline stage with skid buffer.
//   pipe_state_t    : stage occupancy state (EMPTY / FULL / SKID)
//   state_occupancy : number of held entries for a given state
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } pipe_state_t;

   function automatic logic [1:0] state_occupancy(input pipe_state_t s);
      logic [1:0] n;
      case (s)
         FULL:    n = 2'd1;
         SKID:    n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the pipeline stage: a control field and a data field.
// Ports:
//   clk        : clock
//   load       : capture d_ctrl/d_data
//   clear_ctrl : zero the control field only (slot becomes a bubble)
//   clear_all  : zero both fields
//   d_ctrl     : control bits to load
//   d_data     : data payload to load
//   q_ctrl     : held control bits
//   q_data     : held data payload
// Priority: clear_all > clear_ctrl > load. clear_ctrl holds the data field.
module pipe_slot #(
   parameter int CTRL_W = 4,
   parameter int DATA_W = 69
) (
   input  logic              clk,
   input  logic              load,
   input  logic              clear_ctrl,
   input  logic              clear_all,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   output logic [CTRL_W-1:0] q_ctrl,
   output logic [DATA_W-1:0] q_data
);

   logic [CTRL_W-1:0] ctrl_q, ctrl_d;
   logic [DATA_W-1:0] data_q, data_d;

   always_comb begin
      ctrl_d = ctrl_q;
      data_d = data_q;
      if (clear_all) begin
         ctrl_d = '0;
         data_d = '0;
      end else if (clear_ctrl) begin
         ctrl_d = '0;
      end else if (load) begin
         ctrl_d = d_ctrl;
         data_d = d_data;
      end
   end

   always_ff @(posedge clk) begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
   end

   assign q_ctrl = ctrl_q;
   assign q_data = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a one-entry skid
// buffer. in_ready comes straight from the state register, so there is no
// combinational path from out_ready back upstream.
// Ports:
//   clk, reset (sync, active-high), flush (sync squash)
//   in_valid/in_ready/in_ctrl/in_data     : upstream handshake + payload
//   out_valid/out_ready/out_ctrl/out_data : downstream handshake + payload
//   occupancy                             : entries held (0..2)
//
// state | meaning
// EMPTY | no entries; outputs invalid, ready to accept
// FULL  | MAIN holds one word driving the outputs
// SKID  | MAIN and SKID both hold words; upstream stalled
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int CTRL_W = 4,
   parameter int DATA_W = 69
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   pipe_state_t state_q, state_d;

   logic accept, consume;
   logic main_load, main_clr, main_sel_skid;
   logic skid_load, skid_clr;

   logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
   logic [DATA_W-1:0] main_data, skid_data, main_d_data;

   assign in_ready  = (state_q != SKID);
   assign out_valid = (state_q != EMPTY);
   assign occupancy = state_occupancy(state_q);
   assign accept    = in_valid & in_ready;
   assign consume   = out_valid & out_ready;

   always_comb begin
      state_d       = state_q;
      main_load     = 1'b0;
      main_clr      = 1'b0;
      main_sel_skid = 1'b0;
      skid_load     = 1'b0;
      skid_clr      = 1'b0;
      case (state_q)
         EMPTY: begin
            if (accept) begin
               main_load = 1'b1;
               state_d   = FULL;
            end
         end
         FULL: begin
            if (accept && consume) begin
               main_load = 1'b1;
            end else if (accept) begin
               skid_load = 1'b1;
               state_d   = SKID;
            end else if (consume) begin
               main_clr  = 1'b1;
               state_d   = EMPTY;
            end
         end
         SKID: begin
            if (consume) begin
               main_load     = 1'b1;
               main_sel_skid = 1'b1;
               skid_clr      = 1'b1;
               state_d       = FULL;
            end
         end
         default: state_d = EMPTY;
      endcase
      // Squash wins over any handshake in the same cycle; the presented
      // input is dropped and both slots become bubbles.
      if (flush || reset) begin
         state_d   = EMPTY;
         main_load = 1'b0;
         skid_load = 1'b0;
         main_clr  = 1'b1;
         skid_clr  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   assign main_d_ctrl = main_sel_skid ? skid_ctrl : in_ctrl;
   assign main_d_data = main_sel_skid ? skid_data : in_data;

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk        (clk),
      .load       (main_load),
      .clear_ctrl (main_clr),
      .clear_all  (reset),
      .d_ctrl     (main_d_ctrl),
      .d_data     (main_d_data),
      .q_ctrl     (main_ctrl),
      .q_data     (main_data)
   );

   pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk        (clk),
      .load       (skid_load),
      .clear_ctrl (skid_clr),
      .clear_all  (reset),
      .d_ctrl     (in_ctrl),
      .d_data     (in_data),
      .q_ctrl     (skid_ctrl),
      .q_data     (skid_data)
   );

   assign out_ctrl = main_ctrl;
   assign out_data = main_data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed steps plus a random phase, with a
// queue scoreboard fed on accept and drained on consume.
module tb_pipe_stage_skid;

   localparam int CW = 4;
   localparam int DW = 69;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, out_ready;
   logic [CW-1:0] in_ctrl;
   logic [DW-1:0] in_data;
   logic          in_ready, out_valid;
   logic [CW-1:0] out_ctrl;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   typedef logic [CW+DW-1:0] word_t;
   word_t sb[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   task automatic check(input string tag, input logic [CW+DW-1:0] obs,
                        input logic [CW+DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
      in_valid = v;
      in_ctrl  = c;
      in_data  = d;
   endtask

   // Scoreboard monitor: compare current outputs against the model queue,
   // then apply this cycle's handshakes to the queue.
   always @(negedge clk) begin
      if (mon_en) begin
         check("sb_occupancy", word_t'(occupancy), word_t'(sb.size()));
         check("sb_in_ready", word_t'(in_ready), word_t'(sb.size() < 2));
         check("sb_out_valid", word_t'(out_valid), word_t'(sb.size() > 0));
         if (sb.size() > 0)
            check("sb_word", {out_ctrl, out_data}, sb[0]);
         else
            check("sb_bubble_ctrl", word_t'(out_ctrl), '0);
         if (reset || flush) begin
            sb.delete();
         end else begin
            if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            if (in_valid && in_ready) sb.push_back({in_ctrl, in_data});
         end
      end
   end

   initial begin
      logic ir;
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b1, 4'hF, 69'h0_AAAA_AAAA_AAAA_AAAA);
      repeat (2) next_cycle();
      reset  = 1'b0;
      mon_en = 1'b1;
      // word AA loads, then reset again with input still presented
      next_cycle();
      reset = 1'b1;
      next_cycle();
      @(negedge clk);
      check("rst_out_valid", word_t'(out_valid), '0);
      check("rst_out_ctrl", word_t'(out_ctrl), '0);
      check("rst_out_data", word_t'(out_data), '0);
      check("rst_occupancy", word_t'(occupancy), '0);
      next_cycle();
      reset = 1'b0;
      drive(1'b0, '0, '0);
      @(negedge clk);
      check("post_rst_in_ready", word_t'(in_ready), word_t'(1));

      // Streaming, one word per cycle, one cycle latency
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         next_cycle();
         drive(1'b1, 4'h3, DW'(i));
         @(negedge clk);
         check("stream_in_ready", word_t'(in_ready), word_t'(1));
         if (i > 1) check("stream_data", {out_ctrl, out_data}, {4'h3, DW'(i - 1)});
      end
      next_cycle();
      drive(1'b0, '0, '0);
      @(negedge clk);
      check("stream_last", {out_ctrl, out_data}, {4'h3, DW'(8)});
      next_cycle();
      @(negedge clk);
      check("stream_drained", word_t'(out_valid), '0);

      // Stall then release: A, B, C
      out_ready = 1'b0;
      drive(1'b1, 4'h5, DW'('hA0));
      next_cycle();
      drive(1'b1, 4'h6, DW'('hB0));
      @(negedge clk);
      check("stall_a_main", word_t'(out_data), word_t'('hA0));
      next_cycle();
      drive(1'b1, 4'h7, DW'('hC0));
      @(negedge clk);
      check("stall_occ2", word_t'(occupancy), word_t'(2));
      check("stall_in_ready", word_t'(in_ready), '0);
      check("stall_a_out", {out_ctrl, out_data}, {4'h5, DW'('hA0)});
      next_cycle();
      out_ready = 1'b1;
      @(negedge clk);
      check("release_a", word_t'(out_data), word_t'('hA0));
      next_cycle();
      @(negedge clk);
      check("release_b", {out_ctrl, out_data}, {4'h6, DW'('hB0)});
      check("release_in_ready", word_t'(in_ready), word_t'(1));
      next_cycle();
      drive(1'b0, '0, '0);
      @(negedge clk);
      check("release_c", {out_ctrl, out_data}, {4'h7, DW'('hC0)});
      next_cycle();
      @(negedge clk);
      check("release_empty", word_t'(out_valid), '0);

      // Flush in SKID state with D presented
      out_ready = 1'b0;
      drive(1'b1, 4'h9, DW'('hE0));
      next_cycle();
      drive(1'b1, 4'hA, DW'('hF0));
      next_cycle();
      drive(1'b1, 4'hB, DW'('hD0));
      flush = 1'b1;
      @(negedge clk);
      check("pre_flush_occ", word_t'(occupancy), word_t'(2));
      next_cycle();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      @(negedge clk);
      check("flush_out_valid", word_t'(out_valid), '0);
      check("flush_out_ctrl", word_t'(out_ctrl), '0);
      check("flush_occ", word_t'(occupancy), '0);
      check("flush_in_ready", word_t'(in_ready), word_t'(1));
      out_ready = 1'b1;
      repeat (3) next_cycle();

      // Flush + reset together in FULL: data cleared
      out_ready = 1'b0;
      drive(1'b1, 4'hC, 69'h1_2345_6789_ABCD_EF01);
      next_cycle();
      drive(1'b0, '0, '0);
      @(negedge clk);
      check("full_g", word_t'(out_data), word_t'(69'h1_2345_6789_ABCD_EF01));
      next_cycle();
      flush = 1'b1; reset = 1'b1;
      next_cycle();
      flush = 1'b0; reset = 1'b0;
      @(negedge clk);
      check("fr_out_data", word_t'(out_data), '0);
      check("fr_out_ctrl", word_t'(out_ctrl), '0);

      // Flush alone in FULL, with an input presented (dropped)
      drive(1'b1, 4'hD, DW'('h4242));
      next_cycle();
      drive(1'b1, 4'h1, DW'('h777));
      flush = 1'b1;
      @(negedge clk);
      check("pre_flush_h", {out_ctrl, out_data}, {4'hD, DW'('h4242)});
      next_cycle();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      @(negedge clk);
      check("flush_keeps_data", word_t'(out_data), word_t'('h4242));
      check("flush_clears_ctrl", word_t'(out_ctrl), '0);
      check("flush_h_occ", word_t'(occupancy), '0);

      // Random valid/ready/flush
      for (int n = 0; n < 10000; n++) begin
         next_cycle();
         drive(1'($urandom_range(0, 1)), CW'($urandom), DW'({$urandom, $urandom, $urandom}));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 63) == 0);
         if ((n % 16) == 0) begin
            #1;
            ir = in_ready;
            out_ready = ~out_ready;
            #1;
            check("in_ready_comb", word_t'(in_ready), word_t'(ir));
            out_ready = ~out_ready;
         end
      end
      next_cycle();
      flush = 1'b0;
      drive(1'b0, '0, '0);
      out_ready = 1'b1;
      repeat (4) next_cycle();
      @(negedge clk);
      check("drain_empty", word_t'(sb.size()), '0);
      mon_en = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a one-entry skid buffer, and a synchronous flush. It replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) so that stages can stall or squash without combinational ready paths crossing the stage boundary. Payload is split into a control field, forced to zero whenever the stage holds a bubble, and a data field that is merely held.

## Interface
Parameters:
- CTRL_W, 4: control-bit width (regWrite, memToReg, …); zeroed on bubble/flush/reset.
- DATA_W, 69: data payload width (e.g. 32+32+5 for MEM/WB).

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream has a word this cycle.
- in_ready  out  1  stage can accept; registered, no combinational path from out_ready.
- in_ctrl  in  CTRL_W  upstream control bits.
- in_data  in  DATA_W  upstream data payload.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream consumes when out_valid is also high.
- out_ctrl  out  CTRL_W  control bits; all zero whenever out_valid=0.
- out_data  out  DATA_W  data payload; undefined content when out_valid=0.
- occupancy  out  2  entries held: 0, 1 or 2.

## Operation
- Two slots: MAIN (drives outputs) and SKID. State: EMPTY (0 entries), FULL (MAIN only), SKID (both).
- Accept = in_valid & in_ready. Consume = out_valid & out_ready.
- EMPTY: accept -> MAIN<=input, FULL. Otherwise stay.
- FULL: accept & consume -> MAIN<=input, stay FULL. Accept & !consume -> SKID<=input, go SKID. !accept & consume -> EMPTY. Neither -> hold.
- SKID: in_ready=0, so in_valid is ignored. Consume -> MAIN<=SKID, FULL. Otherwise hold both.
- in_ready = (state != SKID), derived from the state register only.
- out_valid = (state != EMPTY); occupancy = 0/1/2 for EMPTY/FULL/SKID.
- Bubble rule: a slot's ctrl field is cleared to 0 whenever the slot becomes empty. out_ctrl therefore never shows stale control bits.
- flush: next state EMPTY, both ctrl fields 0. Flush overrides accept and consume in the same cycle; an input presented with flush is dropped. Data fields are not cleared.
- reset: same as flush, and both data fields are also cleared to 0. Reset overrides flush.
- Ordering: words leave in acceptance order; no word is duplicated or lost except by flush or reset.

## Timing
- Reset values: out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1 (cycle after reset is sampled).
- Latency: 1 cycle from accept to out_valid, when empty.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Stall absorption: after out_ready falls, in_ready falls one cycle later. The word accepted in that cycle lands in SKID.
- Recovery: in_ready rises the cycle after the first consume from SKID.
- Flush or reset mid-operation (any state): EMPTY on the next edge, with in_ready=1.

## Structure
- Package pipe_pkg: typedef enum logic [1:0] {EMPTY, FULL, SKID} pipe_state_t.
- Sub-module pipe_slot, instantiated twice (MAIN, SKID):
  - ctrl and data registers with separate load, clear_ctrl and clear_all controls;
  - sync active-high clear.
- Top level holds the state register and next-state/load logic only.

## Test plan
- Reset with in_valid=1, ctrl=4'hF, data=…AA: out_valid=0, out_ctrl=0, out_data=0, occupancy=0. The cycle after reset releases, in_ready=1.
- Streaming: 8 words (data=1..8, ctrl=4'h3), out_ready=1 -> same words out in order, each 1 cycle later, in_ready stays 1.
- Stall then release:
  - Stimulus: push A, B, C with out_ready=0 from the cycle A appears.
  - Checks: A in MAIN, B in SKID, occupancy=2, in_ready=0, C held upstream.
  - Raise out_ready: output sequence A, B, C with no gap after B.
- Flush in SKID state with in_valid=1 (word D): next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; D never appears.
- Flush and reset together in FULL state: data fields read 0 afterwards (reset wins). Flush alone leaves out_data unchanged but out_ctrl=0.
- Random valid/ready for 10k cycles against a scoreboard: no loss or duplication, out_ctrl=0 whenever out_valid=0, in_ready never depends combinationally on out_ready.
